oram_response_serializer: RTL and testbench

//  Return path of the tracegen host bridge: sits between the ORAM front-end read-data output and the UART TX byte port.

---
 rtl/oram_response_serializer_pkg.sv | 20 ++
 rtl/oram_response_serializer_word_byte_shifter.sv | 43 ++++
 rtl/oram_response_serializer.sv | 125 ++++++++++++
 tb/tb_oram_response_serializer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oram_response_serializer_pkg.sv
// Shared constants for the ORAM response serializer: frame marker, FSM states
// and the byte-counter width helper.
package oram_response_serializer_pkg;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_SEQ,
    ST_DATA,
    ST_CHECK
  } state_e;

  // A one-byte word still needs a one-bit counter.
  function automatic int byte_cnt_width(input int n_bytes);
    return (n_bytes <= 1) ? 1 : $clog2(n_bytes);
  endfunction

endpackage

// File: rtl/oram_response_serializer_word_byte_shifter.sv
// Parallel-load word register that shifts right by one byte per enable and
// exposes the byte currently at the bottom and the one that follows it.
module word_byte_shifter #(
  parameter int Width  = 512,
  parameter int UWidth = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [Width-1:0]  load_data,
  input  logic              shift,
  output logic [UWidth-1:0] low_byte,
  output logic [UWidth-1:0] next_byte
);

  logic [Width-1:0] word_q, word_d, shifted;

  assign shifted = word_q >> UWidth;

  // NOTE: every path assigns word_d after the default, so no latch is inferred.
  always_comb begin
    word_d = word_q;
    if (load) begin
      word_d = load_data;
    end else if (shift) begin
      word_d = shifted;
    end
  end

  // NOTE: the wide datapath register is reset too, so UARTDataIn sourced from it
  // is never X after reset; non-blocking assignment keeps flop updates race-free.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign low_byte  = word_q[UWidth-1:0];
  assign next_byte = shifted[UWidth-1:0];

endmodule

// File: rtl/oram_response_serializer.sv
// Frames one ORAM read word as header, sequence, LSB-first data bytes and an
// XOR checksum, and streams it over a registered valid/ready byte port.
import oram_response_serializer_pkg::*;

module oram_response_serializer #(
  parameter int         FEDWidth   = 512,
  parameter int         UWidth     = 8,
  parameter logic [7:0] HeaderByte = HEADER_BYTE_DEFAULT
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [FEDWidth-1:0] ORAMDataOut,
  input  logic                ORAMDataOutValid,
  output logic                ORAMDataOutReady,
  output logic [UWidth-1:0]   UARTDataIn,
  output logic                UARTDataInValid,
  input  logic                UARTDataInReady,
  output logic [7:0]          FramesSent
);

  localparam int NBytes = FEDWidth / UWidth;
  localparam int CntW   = byte_cnt_width(NBytes);
  localparam logic [CntW-1:0] LastCnt = CntW'(NBytes - 1);

  if (UWidth != 8 || FEDWidth < UWidth || (FEDWidth % UWidth) != 0) begin : g_bad_param
    $error("oram_response_serializer: FEDWidth must be a non-zero multiple of UWidth, UWidth must be 8");
  end

  state_e            state_q, state_d;
  logic [7:0]        seq_q, seq_d;
  logic [7:0]        chk_q, chk_d;
  logic [UWidth-1:0] byte_q, byte_d;
  logic              valid_q, valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              load, shift, word_hs, byte_hs;
  logic [UWidth-1:0] low_byte, next_byte;

  word_byte_shifter #(
    .Width (FEDWidth),
    .UWidth(UWidth)
  ) u_shifter (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (load),
    .load_data(ORAMDataOut),
    .shift    (shift),
    .low_byte (low_byte),
    .next_byte(next_byte)
  );

  assign ORAMDataOutReady = Reset & (state_q == ST_IDLE);
  assign word_hs          = ORAMDataOutValid & ORAMDataOutReady;
  assign byte_hs          = valid_q & UARTDataInReady;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    chk_d   = chk_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (word_hs) begin
        load    = 1'b1;
        chk_d   = seq_q;
        byte_d  = HeaderByte;
        valid_d = 1'b1;
        state_d = ST_HEADER;
      end
      ST_HEADER: if (byte_hs) begin
        byte_d  = seq_q;
        state_d = ST_SEQ;
      end
      ST_SEQ: if (byte_hs) begin
        byte_d  = low_byte;
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      // byte_q holds the data byte being accepted, so it folds into the checksum here.
      ST_DATA: if (byte_hs) begin
        chk_d = chk_q ^ byte_q;
        shift = 1'b1;
        if (cnt_q == LastCnt) begin
          byte_d  = chk_q ^ byte_q;
          state_d = ST_CHECK;
        end else begin
          byte_d = next_byte;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
      ST_CHECK: if (byte_hs) begin
        seq_d   = seq_q + 8'd1;
        valid_d = 1'b0;
        byte_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      seq_q   <= '0;
      chk_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      chk_q   <= chk_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign UARTDataIn      = byte_q;
  assign UARTDataInValid = valid_q;
  assign FramesSent      = seq_q;

endmodule

// File: tb/tb_oram_response_serializer.sv
// Self-checking bench for oram_response_serializer: frame-level reference model,
// table-driven vectors, randomized UART back-pressure and reset/overlap corners.
module tb_oram_response_serializer;

  localparam int FEDW   = 512;
  localparam int NB     = FEDW / 8;
  localparam int FLEN   = NB + 3;
  localparam logic [7:0] HDR = 8'hA5;

  typedef logic [FEDW-1:0] word_t;

  typedef struct {
    string      name;
    word_t      word;
    logic [7:0] exp_seq;
    logic [7:0] exp_chk;
  } vec_t;

  logic            Clock = 1'b0;
  logic            Reset = 1'b0;
  word_t           ORAMDataOut = '0;
  logic            ORAMDataOutValid = 1'b0;
  logic            ORAMDataOutReady;
  logic [7:0]      UARTDataIn;
  logic            UARTDataInValid;
  logic            UARTDataInReady = 1'b0;
  logic [7:0]      FramesSent;

  oram_response_serializer dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .ORAMDataOut     (ORAMDataOut),
    .ORAMDataOutValid(ORAMDataOutValid),
    .ORAMDataOutReady(ORAMDataOutReady),
    .UARTDataIn      (UARTDataIn),
    .UARTDataInValid (UARTDataInValid),
    .UARTDataInReady (UARTDataInReady),
    .FramesSent      (FramesSent)
  );

  always #5 Clock = ~Clock;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         stall_viol = 0;
  logic [7:0] mseq = 8'd0;

  word_t      pend[$];
  logic [7:0] rx[$];
  int         rx_cyc[$];
  int         acc_cyc[$];
  logic [7:0] exp_q[$];
  logic [7:0] saved[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: a whole frame from the word and the model's sequence number.
  task automatic model_push(input word_t w);
    logic [7:0] x, b;
    exp_q.push_back(HDR);
    exp_q.push_back(mseq);
    x = mseq;
    for (int i = 0; i < NB; i++) begin
      b = w[8*i +: 8];
      exp_q.push_back(b);
      x = x ^ b;
    end
    exp_q.push_back(x);
    mseq = mseq + 8'd1;
  endtask

  // One clock: drive the pending word, log handshakes, advance to 1 after the edge.
  task automatic tick();
    logic       pv;
    logic [7:0] pb;
    ORAMDataOutValid = (pend.size() > 0);
    ORAMDataOut      = (pend.size() > 0) ? pend[0] : '0;
    #0;
    if (UARTDataInValid && UARTDataInReady) begin
      rx.push_back(UARTDataIn);
      rx_cyc.push_back(cyc + 1);
    end
    if (ORAMDataOutValid && ORAMDataOutReady) begin
      acc_cyc.push_back(cyc + 1);
      model_push(pend[0]);
      void'(pend.pop_front());
    end
    pv = UARTDataInValid && !UARTDataInReady;
    pb = UARTDataIn;
    @(posedge Clock);
    #1;
    cyc++;
    if (pv && (!UARTDataInValid || UARTDataIn !== pb)) stall_viol++;
    ORAMDataOutValid = (pend.size() > 0);
    ORAMDataOut      = (pend.size() > 0) ? pend[0] : '0;
  endtask

  task automatic run(input string name, input int pct, input int budget);
    int n;
    n = 0;
    while ((pend.size() > 0 || rx.size() < exp_q.size()) && n < budget) begin
      UARTDataInReady = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      tick();
      n++;
    end
    UARTDataInReady = 1'b1;
    check({name, "_in_budget"}, 64'(n < budget), 64'd1);
  endtask

  task automatic compare_stream(input string name);
    int mism, lim;
    check({name, "_len"}, 64'(rx.size()), 64'(exp_q.size()));
    lim  = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
    mism = 0;
    for (int i = 0; i < lim; i++) if (rx[i] !== exp_q[i]) mism++;
    check({name, "_byte_mismatches"}, 64'(mism), 64'd0);
  endtask

  task automatic clear_logs();
    rx.delete();
    rx_cyc.delete();
    acc_cyc.delete();
    exp_q.delete();
    mseq = 8'd0;
  endtask

  task automatic do_reset();
    Reset            = 1'b0;
    UARTDataInReady  = 1'b0;
    ORAMDataOutValid = 1'b0;
    pend.delete();
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    clear_logs();
  endtask

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < FEDW / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[5];
    word_t ramp, w_ff, w_00, w_5a, w_01, wa, wb;
    int    n;

    for (int i = 0; i < NB; i++) ramp[8*i +: 8] = 8'(i);
    w_ff = '1;
    w_00 = '0;
    w_5a = '0;
    w_5a[7:0] = 8'h5A;
    for (int i = 0; i < NB; i++) w_01[8*i +: 8] = 8'h01;
    tbl[0] = '{"ramp", ramp, 8'h00, 8'h00};
    tbl[1] = '{"all_ff", w_ff, 8'h01, 8'h01};
    tbl[2] = '{"all_00", w_00, 8'h02, 8'h02};
    tbl[3] = '{"one_5a", w_5a, 8'h03, 8'h59};
    tbl[4] = '{"all_01", w_01, 8'h04, 8'h04};

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    check("rst_oram_ready", 64'(ORAMDataOutReady), 64'd0);
    check("rst_uart_valid", 64'(UARTDataInValid), 64'd0);
    check("rst_uart_data", 64'(UARTDataIn), 64'd0);
    check("rst_frames", 64'(FramesSent), 64'd0);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("post_rst_oram_ready", 64'(ORAMDataOutReady), 64'd1);
    clear_logs();

    // Table-driven frames, ready held high
    for (int k = 0; k < 5; k++) begin
      pend.push_back(tbl[k].word);
      UARTDataInReady = 1'b1;
      tick();
      check({tbl[k].name, "_hdr_valid_next"}, 64'(UARTDataInValid), 64'd1);
      check({tbl[k].name, "_hdr_byte"}, 64'(UARTDataIn), 64'(HDR));
      check({tbl[k].name, "_busy_not_ready"}, 64'(ORAMDataOutReady), 64'd0);
      run(tbl[k].name, 100, 200);
      check({tbl[k].name, "_seq"}, 64'(rx[k*FLEN + 1]), 64'(tbl[k].exp_seq));
      check({tbl[k].name, "_chk"}, 64'(rx[k*FLEN + FLEN - 1]), 64'(tbl[k].exp_chk));
    end
    compare_stream("table");
    check("table_frames", 64'(FramesSent), 64'd5);
    check("t1_frame_cycles", 64'(rx_cyc[FLEN-1] - acc_cyc[0]), 64'd67);

    // Back-to-back frames: one idle cycle between them
    do_reset();
    pend.push_back(w_ff);
    pend.push_back(w_00);
    run("b2b", 100, 400);
    compare_stream("b2b");
    check("b2b_seq0", 64'(rx[1]), 64'h00);
    check("b2b_seq1", 64'(rx[FLEN + 1]), 64'h01);
    check("b2b_chk0", 64'(rx[FLEN - 1]), 64'h00);
    check("b2b_chk1", 64'(rx[2*FLEN - 1]), 64'h01);
    check("b2b_accept_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'(FLEN + 1));
    check("b2b_idle_gap", 64'(rx_cyc[FLEN] - rx_cyc[FLEN-1]), 64'd2);

    // Random back-pressure gives the same byte stream
    do_reset();
    wa = rand_word();
    wb = rand_word();
    pend.push_back(wa);
    pend.push_back(wb);
    pend.push_back(ramp);
    run("bp_ref", 100, 600);
    saved = rx;
    do_reset();
    stall_viol = 0;
    pend.push_back(wa);
    pend.push_back(wb);
    pend.push_back(ramp);
    run("bp_rand", 30, 20000);
    compare_stream("bp_rand");
    n = 0;
    for (int i = 0; i < saved.size() && i < rx.size(); i++) if (saved[i] !== rx[i]) n++;
    check("bp_vs_ready1_len", 64'(rx.size()), 64'(saved.size()));
    check("bp_vs_ready1_mism", 64'(n), 64'd0);
    check("bp_stall_stable", 64'(stall_viol), 64'd0);

    // 257 frames: sequence number wraps
    do_reset();
    for (int i = 0; i < 257; i++) pend.push_back(rand_word());
    run("wrap", 100, 20000);
    compare_stream("wrap");
    check("wrap_seq_257", 64'(rx[256*FLEN + 1]), 64'h00);
    check("wrap_frames", 64'(FramesSent), 64'h01);

    // Asynchronous reset in the middle of the data bytes
    do_reset();
    pend.push_back(ramp);
    n = 0;
    while (rx.size() < 22 && n < 200) begin
      UARTDataInReady = 1'b1;
      tick();
      n++;
    end
    check("mid_rst_reach_byte20", 64'(rx.size()), 64'd22);
    check("mid_rst_valid_before", 64'(UARTDataInValid), 64'd1);
    #1;
    Reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(UARTDataInValid), 64'd0);
    check("mid_rst_data", 64'(UARTDataIn), 64'd0);
    check("mid_rst_oram_ready", 64'(ORAMDataOutReady), 64'd0);
    check("mid_rst_frames", 64'(FramesSent), 64'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    clear_logs();
    pend.push_back(ramp);
    run("after_rst", 100, 200);
    compare_stream("after_rst");
    check("after_rst_hdr", 64'(rx[0]), 64'(HDR));
    check("after_rst_seq", 64'(rx[1]), 64'h00);
    check("after_rst_frames", 64'(FramesSent), 64'd1);

    // Second word held valid during a frame is sent untouched as the next frame
    rx.delete();
    rx_cyc.delete();
    acc_cyc.delete();
    exp_q.delete();
    wa = rand_word();
    wb = rand_word();
    pend.push_back(wa);
    pend.push_back(wb);
    run("hold", 100, 400);
    compare_stream("hold");
    check("hold_accept_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'(FLEN + 1));
    check("hold_frames", 64'(FramesSent), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
